// File: rtl/noc_pkg.sv
// Purpose: shared flit/arbiter types and defaults for the NOC output-port logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

  // Flit type lives in the top two bits of every flit.
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/noc_rr_pick.sv
// Purpose: combinational round-robin picker; first requester after ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides whether the pick is used.
// Ports: req (request vector), ptr (last winner), gnt (one-hot), idx (winner index).
module noc_rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  // Search ptr+1 .. ptr+NUM_IN (mod NUM_IN) so the last winner has lowest priority.
  always_comb begin
    int   k;
    logic found;
    k     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      k = (int'(ptr) + i) % NUM_IN;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/noc_out_arb.sv
// Purpose: output-port arbiter, packet-atomic round-robin over NUM_IN inputs with credit tracking.
// Latency: flit granted in cycle N is on valid_o/data_o in cycle N+1; one flit/cycle sustained.
// Backpressure: grants stop while credit_cnt is zero; credit_i returns one downstream slot.
// Ports: clk, rst (async active-low), req_i/data_i (FIFO heads), grant_o (pop strobe),
//        valid_o/data_o (registered link), credit_i (slot freed), err_o (sticky protocol error).
// Optional: define NOC_ARB_ERR_CHECK_EN to build the protocol checker behind err_o.
module noc_out_arb
  import noc_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CREDITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN*DATA_W-1:0] data_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  input  logic                     credit_i,
  output logic                     err_o
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(CREDITS + 1);

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  win_idx;
  logic [NUM_IN-1:0] pick_gnt;
  logic [CNT_W-1:0]  credit_cnt;
  logic [DATA_W-1:0] win_dat;
  flit_type_e        win_type;
  logic              can_send;
  logic              gnt_vld;

  noc_rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign can_send = (credit_cnt != '0);
  // While a packet is in flight only its owner's flit is considered.
  assign win_idx  = (state == LOCKED) ? owner : pick_idx;
  assign win_dat  = data_i[int'(win_idx)*DATA_W +: DATA_W];
  assign win_type = flit_type_e'(win_dat[DATA_W-1 -: 2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // rst gates the grant so FIFOs are never popped while the block is held in reset.
  always_comb begin
    state_nxt = state;
    grant_o   = '0;
    gnt_vld   = 1'b0;
    case (state)
      IDLE: begin
        if (rst && can_send && (|req_i)) begin
          gnt_vld = 1'b1;
          grant_o = pick_gnt;
          if (win_type == FLIT_HEAD || win_type == FLIT_BODY) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (rst && can_send && req_i[owner]) begin
          gnt_vld        = 1'b1;
          grant_o[owner] = 1'b1;
          if (win_type == FLIT_TAIL || win_type == FLIT_SINGLE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= '0;
      rr_ptr     <= IDX_W'(NUM_IN - 1);
      credit_cnt <= CNT_W'(CREDITS);
      valid_o    <= 1'b0;
      data_o     <= '0;
    end else begin
      valid_o <= gnt_vld;
      if (gnt_vld) begin
        data_o <= win_dat;
        rr_ptr <= win_idx;
        if (state == IDLE) owner <= win_idx;
      end
      // A grant and a returning credit in the same cycle cancel out.
      if (gnt_vld && !credit_i)
        credit_cnt <= credit_cnt - 1'b1;
      else if (!gnt_vld && credit_i && credit_cnt != CNT_W'(CREDITS))
        credit_cnt <= credit_cnt + 1'b1;
    end
  end

`ifdef NOC_ARB_ERR_CHECK_EN
  logic err_q;
  logic err_set;

  // Type bit 0 is set for head/single: those must only start packets from IDLE.
  assign err_set = (credit_i && (credit_cnt == CNT_W'(CREDITS)) && !gnt_vld)
                || (gnt_vld && (state == LOCKED) &&  win_dat[DATA_W-2])
                || (gnt_vld && (state == IDLE)   && !win_dat[DATA_W-2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | err_set;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_arb.sv
// Purpose: directed self-checking bench for noc_out_arb (NUM_IN=4, DATA_W=16, CREDITS=4).
// Latency: checks grant_o combinationally, link outputs one cycle after each grant.
// Backpressure: exercises credit exhaustion, credit return and owner bubbles.
module tb_noc_out_arb;

  localparam int NUM_IN  = 4;
  localparam int DATA_W  = 16;
  localparam int CREDITS = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_IN-1:0]        req_i;
  logic [NUM_IN*DATA_W-1:0] data_i;
  logic [NUM_IN-1:0]        grant_o;
  logic                     valid_o;
  logic [DATA_W-1:0]        data_o;
  logic                     credit_i;
  logic                     err_o;

  logic [DATA_W-1:0] fl [NUM_IN];
  int vectors     = 0;
  int miscompares = 0;

  assign data_i = {fl[3], fl[2], fl[1], fl[0]};

  always #5 clk = ~clk;

  noc_out_arb #(
    .NUM_IN  (NUM_IN),
    .DATA_W  (DATA_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .data_i   (data_i),
    .grant_o  (grant_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .credit_i (credit_i),
    .err_o    (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic all_single();
    for (int i = 0; i < NUM_IN; i++) fl[i] = 16'hC000 | 16'(i);
  endtask

  initial begin
    logic [3:0] e;
    rst      = 1'b0;
    req_i    = 4'hF;
    credit_i = 1'b0;
    all_single();

    // Reset state; requests present but no grant while held in reset.
    repeat (3) tick();
    check("rst_grant", grant_o, 4'b0000);
    check("rst_valid", valid_o, 1'b0);
    check("rst_data",  data_o, 16'h0000);
    check("rst_err",   err_o, 1'b0);
    check("rst_cnt",   dut.credit_cnt, CREDITS);

    // All ports send singles, credit every cycle: grants rotate 0,1,2,3,0.
    rst      = 1'b1;
    credit_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      e = 4'b0001 << (k % 4);
      check("rot_grant", grant_o, e);
      tick();
      check("rot_valid", valid_o, 1'b1);
      check("rot_data",  data_o, 16'hC000 | 16'(k % 4));
    end
    check("rot_cnt", dut.credit_cnt, 4);

    // Port 1 single, then port 2 packet head/body/tail uninterrupted, then port 3.
    #1; check("pkt_g1", grant_o, 4'b0010);
    tick();
    fl[2] = 16'h4002; #1; check("pkt_head_g", grant_o, 4'b0100);
    tick();           check("pkt_head_d", data_o, 16'h4002);
    fl[2] = 16'h0002; #1; check("pkt_body_g", grant_o, 4'b0100);
    tick();           check("pkt_body_d", data_o, 16'h0002);
    fl[2] = 16'h8002; #1; check("pkt_tail_g", grant_o, 4'b0100);
    tick();           check("pkt_tail_d", data_o, 16'h8002);
    fl[2] = 16'hC002; #1; check("pkt_next_g", grant_o, 4'b1000);
    tick();           check("pkt_next_d", data_o, 16'hC003);

    // No credit return: exactly four grants, then stall.
    credit_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = 4'b0001 << k;
      check("cr_grant", grant_o, e);
      tick();
    end
    #1; check("cr_stall_g", grant_o, 4'b0000);
    check("cr_cnt0", dut.credit_cnt, 0);
    tick();
    check("cr_stall_v", valid_o, 1'b0);
    check("cr_hold_d",  data_o, 16'hC003);
    credit_i = 1'b1;
    #1; check("cr_pulse_g", grant_o, 4'b0000);
    tick();
    credit_i = 1'b0;
    check("cr_cnt1", dut.credit_cnt, 1);
    #1; check("cr_one_g", grant_o, 4'b0001);
    tick();
    check("cr_one_v", valid_o, 1'b1);
    check("cr_one_d", data_o, 16'hC000);
    #1; check("cr_after_g", grant_o, 4'b0000);
    tick();

    // Refill, then port 1 packet with a 3-cycle bubble while port 0 waits.
    req_i    = 4'b0000;
    credit_i = 1'b1;
    repeat (4) tick();
    credit_i = 1'b0;
    check("bub_cnt4", dut.credit_cnt, 4);
    req_i = 4'b0011;
    fl[1] = 16'h4001; #1; check("bub_head_g", grant_o, 4'b0010);
    tick();
    fl[1] = 16'h0001; #1; check("bub_body_g", grant_o, 4'b0010);
    tick();
    req_i = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1; check("bub_gap_g", grant_o, 4'b0000);
      tick();
    end
    check("bub_gap_v", valid_o, 1'b0);
    req_i = 4'b0011;
    fl[1] = 16'h8001; #1; check("bub_tail_g", grant_o, 4'b0010);
    tick();           check("bub_tail_d", data_o, 16'h8001);
    req_i = 4'b0001;  #1; check("bub_p0_g", grant_o, 4'b0001);
    tick();           check("bub_p0_d", data_o, 16'hC000);
    check("bub_cnt0", dut.credit_cnt, 0);

    // Grant and credit in the same cycle at count 2.
    req_i    = 4'b0000;
    credit_i = 1'b1;
    repeat (2) tick();
    check("gc_cnt2", dut.credit_cnt, 2);
    req_i = 4'b0001;
    #1; check("gc_grant", grant_o, 4'b0001);
    tick();
    check("gc_cnt_same", dut.credit_cnt, 2);
    req_i    = 4'b0000;
    credit_i = 1'b0;

    // Reset mid-packet.
    req_i = 4'b0100;
    fl[2] = 16'h4002; #1; check("mr_head_g", grant_o, 4'b0100);
    tick();
    check("mr_valid1", valid_o, 1'b1);
    req_i = 4'b0101;
    fl[2] = 16'h0002;
    rst   = 1'b0;
    #1;
    check("mr_grant0", grant_o, 4'b0000);
    check("mr_valid0", valid_o, 1'b0);
    check("mr_data0",  data_o, 16'h0000);
    check("mr_cnt",    dut.credit_cnt, CREDITS);
    tick();
    rst   = 1'b1;
    req_i = 4'hF;
    all_single();
    #1; check("mr_first_g", grant_o, 4'b0001);
    tick();
    check("mr_first_d", data_o, 16'hC000);
    check("mr_err_clean", err_o, 1'b0);

    // Credit beyond full: saturates; sets the sticky error when the checker is built.
    req_i    = 4'b0000;
    credit_i = 1'b1;
    tick();
    check("ov_cnt_full", dut.credit_cnt, 4);
    check("ov_err_pre",  err_o, 1'b0);
    tick();
    credit_i = 1'b0;
    check("ov_cnt_sat", dut.credit_cnt, 4);
`ifdef NOC_ARB_ERR_CHECK_EN
    check("ov_err_set", err_o, 1'b1);
    repeat (3) tick();
    check("ov_err_sticky", err_o, 1'b1);
`else
    check("ov_err_off", err_o, 1'b0);
    repeat (3) tick();
    check("ov_err_off2", err_o, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noc_out_arb.md
# noc_out_arb

Output-port arbiter and credit scheduler for the NOC router. It shares one downstream link between `NUM_IN` input buffers using packet-atomic round-robin arbitration. It tracks downstream buffer space with a credit counter and registers the winning flit onto the link. The block sits between the router's input FIFOs and the `valid`/`data`/`credit` link to the next hop.

## Interface
Parameters:
- `NUM_IN`, 4: number of requesting input ports, 2..8.
- `DATA_W`, 16: flit width; bits [DATA_W-1:DATA_W-2] carry the flit type.
- `CREDITS`, 4: downstream buffer depth; also the credit counter reset value, 1..15.

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-low.
- `clk`, input, 1: clock; all logic on posedge.
- `rst`, input, 1: asynchronous active-low reset.
- `req_i`, input, NUM_IN: input port i has a flit at its FIFO head.
- `data_i`, input, NUM_IN*DATA_W: packed head flits; port i occupies bits [i*DATA_W +: DATA_W].
- `grant_o`, output, NUM_IN: one-hot combinational pop strobe to the winning FIFO.
- `valid_o`, output, 1: registered flit-valid toward downstream.
- `data_o`, output, DATA_W: registered flit toward downstream.
- `credit_i`, input, 1: single-cycle pulse; downstream freed one slot.
- `err_o`, output, 1: sticky protocol error (see Configuration).

## Operation
- Flit type field (top two bits):
  - 01: head.
  - 00: body.
  - 10: tail.
  - 11: single (head and tail in one flit).
- FSM states:
  - IDLE: no packet owns the link.
  - LOCKED: `owner` register holds the port whose packet is in flight.
- Send condition: `can_send = (credit_cnt != 0)`.
- IDLE with `can_send` and any `req_i`:
  - Round-robin pick: search from `rr_ptr+1` upward, wrapping modulo NUM_IN; first requester wins.
  - Assert `grant_o[w]`, set `rr_ptr <= w`.
  - Winning flit type 01 or 00: go LOCKED with `owner <= w`.
  - Winning flit type 10 or 11: stay IDLE.
- LOCKED:
  - Only `owner` is eligible. If `req_i[owner]` is low (bubble), no grant, stay LOCKED.
  - Grant with type 10 or 11 returns to IDLE. Other requesters never interleave mid-packet.
- Credit counter `credit_cnt`, width `$clog2(CREDITS+1)`:
  - Grant alone: -1.
  - `credit_i` alone: +1.
  - Grant and `credit_i` in the same cycle: unchanged.
  - Saturates at CREDITS; never decrements below 0 because a grant requires `can_send`.
- With `credit_cnt == 0`: `grant_o = 0`, FSM holds state, `valid_o` deasserts the next cycle.
- `rr_ptr` wraps from NUM_IN-1 to 0.

## Timing
- `grant_o` is combinational from `req_i`, `data_i` type, FSM state, and `credit_cnt` in the same cycle.
- Latency: a flit granted in cycle N appears on `valid_o`/`data_o` in cycle N+1. Sustained throughput is one flit per cycle while credits last.
- A credit arriving in cycle N can enable a grant in cycle N+1. A grant and credit in the same cycle do not enable an extra grant.
- `data_o` holds its last value when `valid_o` = 0.
- Reset values: `valid_o`=0, `data_o`=0, `err_o`=0, `credit_cnt`=CREDITS, state IDLE, `rr_ptr`=NUM_IN-1 so port 0 has first priority.
- Reset asserted mid-packet: the packet is abandoned, all registers take reset values immediately, and `grant_o` drops to 0 combinationally.

## Configuration
- Macro: `NOC_ARB_ERR_CHECK_EN`.
- Defined: `err_o` sets and stays high until reset on any of:
  - `credit_i` while `credit_cnt == CREDITS` and no grant that cycle (credit overflow);
  - a head or single flit granted in LOCKED;
  - a body or tail flit granted in IDLE.
- Error detection does not change arbitration or forwarding.
- Undefined: `err_o` tied to 0 and no checker logic is synthesized.

## Structure
- Shared package `noc_pkg`:
  - `flit_type_e` enum: `FLIT_BODY`=2'b00, `FLIT_HEAD`=2'b01, `FLIT_TAIL`=2'b10, `FLIT_SINGLE`=2'b11.
  - `arb_state_e`: IDLE, LOCKED.
  - Default `DATA_W` constant.
- One sub-module, `noc_rr_pick`: combinational round-robin picker. Inputs: request vector, pointer. Outputs: one-hot grant, winner index.
- Credit counter, FSM, output register, and checker live in `noc_out_arb`.

## Test plan
- Reset, then `req_i`=4'b1111 with all flits single (16'hC0xx), `credit_i` pulsed every cycle: grants rotate 0,1,2,3,0, one per cycle, and `data_o` follows one cycle later.
- Port 2 sends head 16'h4002, body 16'h0002, tail 16'h8002 while ports 0, 1, 3 request continuously: grants 2,2,2 back-to-back, then port 3 next.
- CREDITS=4 with no `credit_i`, ports requesting single flits: exactly 4 grants, then `grant_o`=0. One `credit_i` pulse yields exactly one more grant, in the following cycle.
- Locked owner port 1 drops `req_i` for 3 cycles mid-packet while port 0 requests: no grants for 3 cycles, then port 1's tail is granted, then port 0.
- Grant and `credit_i` in the same cycle at `credit_cnt`=2: count stays 2.
- Assert `rst` low mid-packet: `valid_o`=0, credit count back to CREDITS, and port 0 wins first after release. With `NOC_ARB_ERR_CHECK_EN`, an extra `credit_i` at full credits sets `err_o`=1, and it stays 1.
